// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int MEM_ADDR_W = 28;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Bits [3:0] address a byte within the 16-byte block; the rest splits into tag and index.
    function automatic int tag_w(input int sets, input int addr_w);
        return addr_w - 4 - $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_controller_if.sv
// Fetch-side and instruction-memory-side signals of the instruction cache.
interface icache_controller_if #(
    parameter int ADDR_W = 32
);
    import icache_pkg::*;

    logic                  cpu_read;
    logic [ADDR_W-1:0]     cpu_address;
    logic [WORD_W-1:0]     cpu_instruction;
    logic                  cpu_busywait;
    logic                  mem_read;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [BLOCK_W-1:0]    mem_readdata;
    logic                  mem_busywait;

    // The cache itself: serves fetch requests and issues block reads.
    modport slave (
        input  cpu_read, cpu_address, mem_readdata, mem_busywait,
        output cpu_instruction, cpu_busywait, mem_read, mem_address
    );

    // The environment: fetch stage plus instruction memory.
    modport master (
        output cpu_read, cpu_address, mem_readdata, mem_busywait,
        input  cpu_instruction, cpu_busywait, mem_read, mem_address
    );

endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: combinational read port, one synchronous write port,
// valid bits cleared asynchronously by reset.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int TAG_W = 25,
    parameter int IDX_W = idx_w(SETS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [IDX_W-1:0]   i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [BLOCK_W-1:0] o_rd_block,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [BLOCK_W-1:0] i_wr_block
);

    logic [SETS-1:0]    r_valid;
    logic [TAG_W-1:0]   r_tag   [SETS];
    logic [BLOCK_W-1:0] r_block [SETS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tags and data need no reset: a line is only ever read through its valid bit.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]   <= i_wr_tag;
            r_block[i_wr_index] <= i_wr_block;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_block = r_block[i_rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache controller with one-block refill FSM.
// Optional ICACHE_PERF_CNT_EN adds saturating hit_count/miss_count outputs.
module icache_controller
    import icache_pkg::*;
#(
    parameter int SETS   = 8,
    parameter int ADDR_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    icache_controller_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(SETS, ADDR_W);
    localparam int LA_W  = ADDR_W - 4;

    state_t             r_state;
    state_t             w_state_next;
    logic [LA_W-1:0]    r_miss_addr;
    logic               r_seen_busy;
    logic               r_mem_read;
    logic [BLOCK_W-1:0] r_fill_block;

    logic [LA_W-1:0]    w_req_line;
    logic [1:0]         w_offset;
    logic               w_valid;
    logic [TAG_W-1:0]   w_tag;
    logic [BLOCK_W-1:0] w_block;
    logic [WORD_W-1:0]  w_word;
    logic               w_hit;
    logic               w_busywait;
    logic               w_unused_bits;

    assign w_req_line    = bus.cpu_address[ADDR_W-1:4];
    assign w_offset      = bus.cpu_address[3:2];
    assign w_unused_bits = ^bus.cpu_address[1:0];

    icache_line_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_lines (
        .clock      (clock),
        .reset      (reset),
        .i_rd_index (w_req_line[IDX_W-1:0]),
        .o_rd_valid (w_valid),
        .o_rd_tag   (w_tag),
        .o_rd_block (w_block),
        .i_wr_en    (r_state == UPDATE),
        .i_wr_index (r_miss_addr[IDX_W-1:0]),
        .i_wr_tag   (r_miss_addr[LA_W-1:IDX_W]),
        .i_wr_block (r_fill_block)
    );

    assign w_hit  = bus.cpu_read & w_valid & (w_tag == w_req_line[LA_W-1:IDX_W]);
    assign w_word = w_block[{w_offset, 5'd0} +: WORD_W];

    always_comb begin
        w_state_next = r_state;
        w_busywait   = 1'b1;
        unique case (r_state)
            IDLE: begin
                w_busywait = bus.cpu_read & ~w_hit;
                if (bus.cpu_read & ~w_hit) begin
                    w_state_next = MEM_READ;
                end
            end
            MEM_READ: begin
                // A low busywait only counts once the memory has acknowledged by going busy.
                if (r_seen_busy & ~bus.mem_busywait) begin
                    w_state_next = UPDATE;
                end
            end
            UPDATE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_seen_busy <= 1'b0;
            r_miss_addr <= '0;
            r_mem_read  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mem_read <= (w_state_next != IDLE);
            if ((r_state == IDLE) && (w_state_next == MEM_READ)) begin
                r_miss_addr <= w_req_line;
            end
            if (r_state == MEM_READ) begin
                r_seen_busy <= (w_state_next == MEM_READ) & (r_seen_busy | bus.mem_busywait);
            end else begin
                r_seen_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if ((r_state == MEM_READ) && (w_state_next == UPDATE)) begin
            r_fill_block <= bus.mem_readdata;
        end
    end

    assign bus.cpu_instruction = w_hit ? w_word : '0;
    assign bus.cpu_busywait    = w_busywait;
    assign bus.mem_read        = r_mem_read;
    assign bus.mem_address     = MEM_ADDR_W'(r_miss_addr);

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if ((r_state == IDLE) && w_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if ((r_state == IDLE) && (w_state_next == MEM_READ) && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Randomized bench for icache_controller against a line-level cache/memory model.
module tb_icache_controller;
    import icache_pkg::*;

    localparam int SETS   = 8;
    localparam int ADDR_W = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    icache_controller_if #(.ADDR_W(ADDR_W)) bus();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_controller #(.SETS(SETS), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction memory: busy for mem_lat cycles per request, then presents the block.
    logic [127:0] imem [64];
    int mem_lat = 3;
    int mem_cnt = 0;
    bit mem_done = 0;

    always @(negedge clock) begin
        if (reset || !bus.mem_read) begin
            bus.mem_busywait = 1'b0;
            mem_done = 0;
        end else if (!mem_done) begin
            if (!bus.mem_busywait) begin
                bus.mem_busywait = 1'b1;
                mem_cnt = mem_lat;
            end else if (mem_cnt > 1) begin
                mem_cnt--;
            end else begin
                bus.mem_busywait = 1'b0;
                bus.mem_readdata = imem[bus.mem_address[5:0]];
                mem_done = 1;
            end
        end
    end

    // Reference cache contents and event counts since the last reset.
    bit          m_valid [SETS];
    logic [31:0] m_tag   [SETS];
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) m_valid[i] = 0;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic access(input logic [31:0] addr, input int lat);
        logic [31:0]  blk;
        logic [127:0] data;
        logic [31:0]  word;
        int idx, off, stall;
        bit hit;
        blk  = addr >> 4;
        idx  = int'(blk % SETS);
        off  = int'(addr[3:2]);
        data = imem[blk[5:0]];
        word = data[off*32 +: 32];
        hit  = m_valid[idx] && (m_tag[idx] == blk / SETS);
        mem_lat = lat;
        @(negedge clock);
        bus.cpu_read = 1'b1;
        bus.cpu_address = addr;
        #1;
        if (hit) begin
            check("hit_busywait", bus.cpu_busywait, 1'b0);
            check("hit_instr", bus.cpu_instruction, word);
            check("hit_mem_read", bus.mem_read, 1'b0);
        end else begin
            check("miss_busywait", bus.cpu_busywait, 1'b1);
            check("miss_instr", bus.cpu_instruction, 32'h0);
            @(posedge clock); #1;
            check("miss_mem_read", bus.mem_read, 1'b1);
            check("miss_mem_addr", bus.mem_address, blk);
            stall = 1;
            while (bus.cpu_busywait && stall < 64) begin
                stall++;
                @(posedge clock); #1;
            end
            // Stalled cycles: the request cycle, then busy period + MEM_READ entry + UPDATE.
            check("miss_stall", stall, lat + 3);
            check("fill_instr", bus.cpu_instruction, word);
            check("fill_mem_read", bus.mem_read, 1'b0);
            m_valid[idx] = 1;
            m_tag[idx] = blk / SETS;
            exp_misses++;
            @(posedge clock); #1;
        end
        exp_hits++;
    endtask

    task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_CNT_EN
        check({tag, "_hits"}, hit_count, exp_hits);
        check({tag, "_misses"}, miss_count, exp_misses);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 64; i++) imem[i] = {$urandom, $urandom, $urandom, $urandom};
        imem[0][31:0]  = 32'h00500093;
        imem[0][63:32] = 32'h00506113;

        reset = 1'b1;
        bus.cpu_read = 1'b0;
        bus.cpu_address = '0;
        bus.mem_readdata = '0;
        model_reset();
        repeat (3) @(negedge clock);
        #1;
        check("rst_busywait", bus.cpu_busywait, 1'b0);
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_addr", bus.mem_address, 28'h0);
        check("rst_instr", bus.cpu_instruction, 32'h0);
        check_counters("rst");
        @(negedge clock);
        reset = 1'b0;

        // Cold miss, same-block hits, then a second block.
        access(32'h0, 3);
        access(32'h4, 2);
        access(32'h8, 1);
        access(32'h10, 2);
        check_counters("seq");

        // Fetch idle: nothing moves.
        @(negedge clock);
        bus.cpu_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.cpu_address = $urandom;
            @(posedge clock); #1;
            check("idle_busywait", bus.cpu_busywait, 1'b0);
            check("idle_mem_read", bus.mem_read, 1'b0);
            check("idle_instr", bus.cpu_instruction, 32'h0);
        end
        access(32'h4, 1);

        // Conflict eviction on index 0.
        access(32'h80, 2);
        access(32'h0, 4);

        // Reset while refilling 0x80.
        @(negedge clock);
        bus.cpu_read = 1'b1;
        bus.cpu_address = 32'h80;
        @(posedge clock); #1;
        check("pre_rst_mem_read", bus.mem_read, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        bus.cpu_read = 1'b0;
        #1;
        check("async_rst_mem_read", bus.mem_read, 1'b0);
        check("async_rst_busywait", bus.cpu_busywait, 1'b0);
        check("async_rst_mem_addr", bus.mem_address, 28'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        access(32'h0, 2);
        access(32'h80, 1);

        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
            access(a, $urandom_range(1, 4));
        end
        check_counters("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
